// File: rtl/mips_pkg.sv
// Shared MIPS definitions: memory opcodes, byte-lane geometry and access decode
// helpers used by the MEM-stage data memory and the control decoder.
package mips_pkg;

    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SB  = 6'h28;

    localparam int LANE_BITS = 8;
    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {
        SZ_NONE,
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } access_size_e;

    function automatic logic is_load_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
               (op == OP_LB) || (op == OP_LBU);
    endfunction

    function automatic logic is_store_op(input logic [5:0] op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    function automatic access_size_e access_size(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW:          return SZ_WORD;
            OP_LH, OP_LHU, OP_SH:  return SZ_HALF;
            OP_LB, OP_LBU, OP_SB:  return SZ_BYTE;
            default:               return SZ_NONE;
        endcase
    endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Load lane select and sign/zero extension; yields 0 for non-load opcodes.
module dm_load_ext
    import mips_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_off,
    input  logic [5:0]  opcode,
    output logic [31:0] value
);

    logic [LANE_BITS-1:0]   lane_byte;
    logic [2*LANE_BITS-1:0] lane_half;

    always_comb begin
        lane_byte = '0;
        lane_half = '0;
        value     = '0;

        case (byte_off)
            2'd0:    lane_byte = word[7:0];
            2'd1:    lane_byte = word[15:8];
            2'd2:    lane_byte = word[23:16];
            default: lane_byte = word[31:24];
        endcase

        lane_half = byte_off[1] ? word[31:16] : word[15:0];

        case (opcode)
            OP_LW:   value = word;
            OP_LH:   value = {{16{lane_half[15]}}, lane_half};
            OP_LHU:  value = {16'h0000, lane_half};
            OP_LB:   value = {{24{lane_byte[7]}}, lane_byte};
            OP_LBU:  value = {24'h000000, lane_byte};
            default: value = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage_dm.sv
// MEM-stage data memory: zero-cycle extended loads, byte/half/word stores
// committed on the clock edge, address fault detection and a store trace.
module mem_stage_dm
    import mips_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] instr,
    input  logic [31:0] pc8,
    output logic [31:0] rdata,
    output logic        addr_err,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic [31:0] wr_pc
);

    localparam int          AW    = $clog2(DEPTH_WORDS);
    localparam logic [31:0] BYTES = 32'(DEPTH_WORDS) * 32'd4;

    logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

    logic [5:0]    opcode;
    logic          is_load;
    logic          is_store;
    access_size_e  size;
    logic [31:0]   off;
    logic          in_range;
    logic          misaligned;
    logic [AW-1:0] idx;
    logic [31:0]   cur_word;
    logic [31:0]   merged;
    logic [31:0]   ext_value;
    logic          unused_instr;

    assign opcode       = instr[31:26];
    assign unused_instr = ^instr[25:0];
    assign is_load      = is_load_op(opcode);
    assign is_store     = is_store_op(opcode);
    assign size         = access_size(opcode);

    assign off      = addr - BASE_ADDR;
    assign in_range = off < BYTES;
    assign idx      = off[AW+1:2];
    assign cur_word = mem[idx];

    always_comb begin
        misaligned = 1'b0;
        case (size)
            SZ_WORD: misaligned = addr[1:0] != 2'b00;
            SZ_HALF: misaligned = addr[0];
            default: misaligned = 1'b0;
        endcase
    end

    assign addr_err = (is_load || is_store) && (misaligned || !in_range);

    // Stores rewrite only their own lanes; the rest of the word is carried over.
    always_comb begin
        merged = cur_word;
        case (size)
            SZ_WORD: merged = wdata;
            SZ_HALF: begin
                if (addr[1])
                    merged[31:16] = wdata[15:0];
                else
                    merged[15:0] = wdata[15:0];
            end
            SZ_BYTE: begin
                case (addr[1:0])
                    2'd0:    merged[7:0]   = wdata[7:0];
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
            end
            default: merged = cur_word;
        endcase
    end

    dm_load_ext u_load_ext (
        .word     (cur_word),
        .byte_off (addr[1:0]),
        .opcode   (opcode),
        .value    (ext_value)
    );

    assign rdata   = (is_load && !addr_err) ? ext_value : 32'h0;
    assign wr_en   = is_store && !addr_err && !rst;
    assign wr_addr = {addr[31:2], 2'b00};
    assign wr_data = merged;
    assign wr_pc   = pc8 - 32'd4;

    // Reset wipes the whole array and takes priority over any pending store.
    always_ff @(posedge clk) begin
        if (rst)
            mem <= '{default: '0};
        else if (wr_en)
            mem[idx] <= wr_data;
    end

endmodule

// File: tb/tb_mem_stage_dm.sv
// Directed self-checking bench for mem_stage_dm with hand-computed expectations.
module tb_mem_stage_dm;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] instr;
    logic [31:0] pc8;
    logic [31:0] rdata;
    logic        addr_err;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [31:0] wr_pc;

    int checks = 0;
    int fails  = 0;

    mem_stage_dm #(
        .DEPTH_WORDS (1024),
        .BASE_ADDR   (32'h0000_0000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .wdata    (wdata),
        .instr    (instr),
        .pc8      (pc8),
        .rdata    (rdata),
        .addr_err (addr_err),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_pc    (wr_pc)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge and are sampled 1ns later, far from posedge.
    task automatic apply_stimulus(input logic r, input logic [5:0] op,
                                  input logic [31:0] a, input logic [31:0] d,
                                  input logic [31:0] p);
        @(negedge clk);
        rst   = r;
        instr = {op, 26'h0};
        addr  = a;
        wdata = d;
        pc8   = p;
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %08h expected %08h", tag, observed, expected);
        end
    endtask

    task automatic commit();
        @(posedge clk);
    endtask

    initial begin
        rst = 1'b1; addr = '0; wdata = '0; instr = '0; pc8 = '0;
        $display("[TB] start");

        // Store presented under reset must be dropped
        apply_stimulus(1'b1, OP_SW, 32'h0, 32'hDEAD_BEEF, 32'h100);
        check_output("rst_wr_en", {31'b0, wr_en}, 32'h0);
        check_output("rst_rdata_t0", rdata, 32'h0);
        commit();

        apply_stimulus(1'b0, OP_LW, 32'h0, 32'h0, 32'h104);
        check_output("lw0_rdata", rdata, 32'h0);
        check_output("lw0_err", {31'b0, addr_err}, 32'h0);

        apply_stimulus(1'b0, OP_SW, 32'h10, 32'h8765_4321, 32'h108);
        check_output("sw10_wr_en", {31'b0, wr_en}, 32'h1);
        check_output("sw10_wr_addr", wr_addr, 32'h10);
        check_output("sw10_wr_data", wr_data, 32'h8765_4321);
        check_output("sw10_wr_pc", wr_pc, 32'h104);
        check_output("sw10_err", {31'b0, addr_err}, 32'h0);
        commit();

        apply_stimulus(1'b0, OP_LW, 32'h10, 32'h0, 32'h10C);
        check_output("lw10", rdata, 32'h8765_4321);
        check_output("lw10_wr_en", {31'b0, wr_en}, 32'h0);
        apply_stimulus(1'b0, OP_LB, 32'h13, 32'h0, 32'h110);
        check_output("lb13", rdata, 32'hFFFF_FF87);
        apply_stimulus(1'b0, OP_LBU, 32'h13, 32'h0, 32'h114);
        check_output("lbu13", rdata, 32'h0000_0087);
        apply_stimulus(1'b0, OP_LH, 32'h12, 32'h0, 32'h118);
        check_output("lh12", rdata, 32'hFFFF_8765);
        apply_stimulus(1'b0, OP_LHU, 32'h10, 32'h0, 32'h11C);
        check_output("lhu10", rdata, 32'h0000_4321);
        apply_stimulus(1'b0, OP_LBU, 32'h11, 32'h0, 32'h120);
        check_output("lbu11", rdata, 32'h0000_0043);

        // Partial stores merge into the existing word
        apply_stimulus(1'b0, OP_SW, 32'h20, 32'h1111_1111, 32'h200);
        commit();
        apply_stimulus(1'b0, OP_SB, 32'h21, 32'h0000_00AB, 32'h204);
        check_output("sb21_wr_data", wr_data, 32'h1111_AB11);
        check_output("sb21_wr_addr", wr_addr, 32'h20);
        commit();
        apply_stimulus(1'b0, OP_SH, 32'h22, 32'h0000_BEEF, 32'h208);
        check_output("sh22_wr_data", wr_data, 32'hBEEF_AB11);
        commit();
        apply_stimulus(1'b0, OP_LW, 32'h20, 32'h0, 32'h20C);
        check_output("lw20", rdata, 32'hBEEF_AB11);

        // Misalignment faults
        apply_stimulus(1'b0, OP_SW, 32'h4, 32'h0A0B_0C0D, 32'h300);
        commit();
        apply_stimulus(1'b0, OP_SW, 32'h6, 32'hFFFF_FFFF, 32'h304);
        check_output("sw6_err", {31'b0, addr_err}, 32'h1);
        check_output("sw6_wr_en", {31'b0, wr_en}, 32'h0);
        commit();
        apply_stimulus(1'b0, OP_LH, 32'h5, 32'h0, 32'h308);
        check_output("lh5_err", {31'b0, addr_err}, 32'h1);
        check_output("lh5_rdata", rdata, 32'h0);
        apply_stimulus(1'b0, OP_LW, 32'h4, 32'h0, 32'h30C);
        check_output("lw4_kept", rdata, 32'h0A0B_0C0D);

        // Out-of-range access just past the top word
        apply_stimulus(1'b0, OP_SW, 32'hFFC, 32'h5555_AAAA, 32'h400);
        check_output("swffc_err", {31'b0, addr_err}, 32'h0);
        commit();
        apply_stimulus(1'b0, OP_SW, 32'h1000, 32'h1234_5678, 32'h404);
        check_output("sw1000_err", {31'b0, addr_err}, 32'h1);
        check_output("sw1000_wr_en", {31'b0, wr_en}, 32'h0);
        commit();
        apply_stimulus(1'b0, OP_LW, 32'hFFC, 32'h0, 32'h408);
        check_output("lwffc", rdata, 32'h5555_AAAA);
        apply_stimulus(1'b0, OP_LB, 32'hFFC, 32'h0, 32'h40C);
        check_output("lbffc", rdata, 32'hFFFF_FFAA);
        apply_stimulus(1'b0, OP_LW, 32'h1000, 32'h0, 32'h410);
        check_output("lw1000_err", {31'b0, addr_err}, 32'h1);
        check_output("lw1000_rdata", rdata, 32'h0);

        // Mid-stream reset clears memory and drops the concurrent store
        apply_stimulus(1'b1, OP_SW, 32'h30, 32'h1234_5678, 32'h500);
        check_output("rst_sw30_wr_en", {31'b0, wr_en}, 32'h0);
        commit();
        apply_stimulus(1'b0, OP_LW, 32'h30, 32'h0, 32'h504);
        check_output("lw30_after_rst", rdata, 32'h0);
        apply_stimulus(1'b0, OP_LW, 32'h10, 32'h0, 32'h508);
        check_output("lw10_after_rst", rdata, 32'h0);

        // Non-access opcode never faults
        apply_stimulus(1'b0, 6'h00, 32'h3, 32'hFFFF_FFFF, 32'h600);
        check_output("add_err", {31'b0, addr_err}, 32'h0);
        check_output("add_rdata", rdata, 32'h0);
        check_output("add_wr_en", {31'b0, wr_en}, 32'h0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage_dm.md
# mem_stage_dm

Data-memory unit for the MEM stage of the five-stage pipelined MIPS core. It consumes the EX/MEM pipeline register outputs: ALU result as byte address, forwarded store data, and the MEM-stage instruction word. It decodes load/store opcodes from that instruction, commits byte/halfword/word stores on the clock edge, and returns a sign- or zero-extended load value combinationally for the MEM/WB register. It also flags misaligned or out-of-range accesses and exposes a write trace for the bench.

## Interface
- DEPTH_WORDS, 1024, number of 32-bit words (4 KiB); power of two
- BASE_ADDR, 32'h0000_0000, byte address of word 0; DEPTH_WORDS*4-aligned

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- addr  in  32  byte address (ALU result from EX/MEM)
- wdata  in  32  store data from EX/MEM
- instr  in  32  MEM-stage instruction; opcode = instr[31:26]
- pc8  in  32  PC+8 of the MEM-stage instruction; used only for trace
- rdata  out  32  extended load result; 0 when not a valid load
- addr_err  out  1  current load/store is misaligned or out of range
- wr_en  out  1  a store commits at the next posedge
- wr_addr  out  32  word-aligned byte address of that store
- wr_data  out  32  full merged word that will be written
- wr_pc  out  32  pc8 − 4 of the committing store

## Operation
- Opcodes: lw 0x23, lh 0x21, lhu 0x25, lb 0x20, lbu 0x24, sw 0x2B, sh 0x29, sb 0x28. Any other opcode is a non-access: no write, rdata=0, addr_err=0.
- Offset: off = addr − BASE_ADDR (32-bit wrap). In range iff off < DEPTH_WORDS*4. Word index = off[log2(DEPTH_WORDS)+1:2].
- Alignment: word ops need addr[1:0]=0. Half ops need addr[0]=0. Byte ops are always aligned.
- addr_err = access opcode AND (misaligned OR out of range). If set, there is no write and rdata=0.
- Little-endian byte lanes. Lane k = bits [8k+7:8k], with k = addr[1:0].
- sb writes wdata[7:0] to lane k.
- sh writes wdata[15:0] to lanes 1:0 when addr[1]=0, and to lanes 3:2 when addr[1]=1.
- sw writes all lanes. Untouched lanes keep their old value (read-modify-merge into wr_data).
- Loads select the same lanes. lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
- wr_en = store opcode AND NOT addr_err AND NOT rst.

## Timing
- rdata and addr_err are combinational from addr/instr and the current memory contents (zero-cycle read).
- A store is visible to a load on the cycle after its commit edge. A load in the same cycle as a store (impossible in pipeline, but legal at the ports) sees the old data.
- Reset: on a posedge with rst=1, every word is cleared to 0 and any concurrent store is dropped.
- Reset is legal mid-stream; the first cycle after reset behaves as if memory were freshly zeroed.
- Memory contents are also 0 at time zero, so rdata=0 and all outputs are defined before the first reset.
- Output values under reset: wr_en=0; rdata reflects the zeroed array after the reset edge; the other outputs follow the inputs combinationally.
- Latency: store is one edge; load is zero cycles. There is no stall or handshake; one access per cycle.

## Structure
- Shared package mips_pkg holds the opcode localparams (OP_LW … OP_SB) and the byte-lane constants, shared with the control decoder.
- One sub-module, dm_load_ext: purely combinational lane select plus sign/zero extension (inputs: word, addr[1:0], opcode; output: 32-bit value).
- The array itself is a reg vector indexed by word index, with a single write port.

## Test plan
- Reset then lw @0x0 → rdata=0, addr_err=0; wr_en stays 0 during rst.
- sw 0x8765_4321 @0x10; next cycle lw @0x10 → 0x8765_4321. Then lb @0x13 → 0xFFFF_FF87, lbu @0x13 → 0x0000_0087, lh @0x12 → 0xFFFF_8765, lhu @0x10 → 0x0000_4321.
- Word @0x20 = 0x1111_1111, then sb 0xAB @0x21 → wr_data=0x1111_AB11; then sh 0xBEEF @0x22 → lw @0x20 = 0xBEEF_AB11.
- sw @0x6 and lh @0x5 → addr_err=1, no write (word @0x4 unchanged), rdata=0.
- sw @0x1000 (DEPTH 1024) → addr_err=1, wr_en=0; lw @0xFFC still returns its prior value.
- A store with rst=1 on the same edge → word remains 0. A non-access opcode (add, 0x00) with addr=0x3 → addr_err=0, rdata=0.
